// File: rtl/prng_pkg.sv
// Shared constants, types and LFSR step function for the PRNG word source.
package prng_pkg;

  localparam int unsigned LFSR_W     = 63;
  localparam int unsigned LFSR_TAP_A = 62;
  localparam int unsigned LFSR_TAP_B = 61;
  localparam int unsigned WORD_MAX_W = 64;

  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 63'h1;

  // Result of advancing the LFSR by a whole word's worth of steps.
  typedef struct packed {
    logic [LFSR_W-1:0]     state;
    logic [WORD_MAX_W-1:0] word;
  } lfsr_step_t;

  // Unrolled nbits-step advance; first feedback bit lands at word[nbits-1].
  function automatic lfsr_step_t lfsr_advance(input logic [LFSR_W-1:0] state,
                                              input int unsigned nbits);
    lfsr_step_t r;
    logic       nb;
    r.state = state;
    r.word  = '0;
    nb      = 1'b0;
    for (int unsigned i = 0; i < WORD_MAX_W; i++) begin
      if (i < nbits) begin
        nb      = r.state[LFSR_TAP_A] ^ r.state[LFSR_TAP_B];
        r.state = {r.state[LFSR_W-2:0], nb};
        r.word  = {r.word[WORD_MAX_W-2:0], nb};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prng_lfsr_core.sv
// 63-bit Fibonacci LFSR advancing WIDTH steps per enabled cycle.
module prng_lfsr_core
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  input  logic              set_seed,
  input  logic              ce,
  output logic [WIDTH-1:0]  word_c,
  output logic [LFSR_W-1:0] state
);

  lfsr_step_t adv_c;
  logic       word_unused_c;

  // Next word and next state from the current state.
  always_comb begin
    adv_c         = lfsr_advance(state, WIDTH);
    word_c        = adv_c.word[WIDTH-1:0];
    word_unused_c = ^adv_c.word;
  end

  // State register: reset, seed load (zero seed would lock up), or advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LFSR_ZERO_SUB;
    end else if (set_seed) begin
      state <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (ce) begin
      state <= adv_c.state;
    end
  end

endmodule

// File: rtl/prng_fifo_source.sv
// Pseudo-random word source: LFSR feeding a FWFT buffer with valid/ack read.
// Optional output range scaling is enabled by defining PRNG_RANGE_EN.
module prng_fifo_source
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned UNDERRUN_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LFSR_W-1:0]            seed,
  input  logic                         set_seed,
`ifdef PRNG_RANGE_EN
  input  logic [WIDTH-1:0]             range_max,
`endif
  output logic [WIDTH-1:0]             random,
  output logic                         valid,
  input  logic                         read_ack,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [UNDERRUN_W-1:0]        underrun_cnt
);

  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [WIDTH-1:0]       raw_word_c;
  logic [LFSR_W-1:0]      lfsr_state_unused;
  logic                   gen_ce_c;
  logic                   push_c;
  logic [WIDTH-1:0]       push_data_c;
  logic                   pop_c;
  logic                   room_c;
  logic                   underrun_c;
  logic [LEVEL_W-1:0]     level_nxt_c;
  logic [LEVEL_W-1:0]     after_pop_c;
  logic [PTR_W-1:0]       rd_ptr_nxt_c;
  logic [WIDTH-1:0]       head_nxt_c;

  prng_lfsr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed     (seed),
    .set_seed (set_seed),
    .ce       (gen_ce_c),
    .word_c   (raw_word_c),
    .state    (lfsr_state_unused)
  );

  // Read-side handshake and space check; a same-cycle pop frees a slot.
  always_comb begin
    pop_c      = read_ack && valid;
    underrun_c = read_ack && !valid;
    room_c     = (level < LEVEL_W'(DEPTH)) || pop_c;
  end

`ifdef PRNG_RANGE_EN
  localparam int unsigned PROD_W  = 2 * WIDTH + 1;
  localparam int unsigned SCALE_W = WIDTH + 1;

  logic [WIDTH-1:0]  stage_word;
  logic              stage_vld;
  logic [PROD_W-1:0] prod_c;
  logic [WIDTH-1:0]  scaled_c;
  logic              prod_unused_c;

  // Scale raw word into 0..range_max; range_max all-ones leaves it unchanged.
  always_comb begin
    prod_c        = PROD_W'(raw_word_c) *
                    PROD_W'(SCALE_W'(range_max) + SCALE_W'(1));
    scaled_c      = prod_c[2*WIDTH-1:WIDTH];
    prod_unused_c = ^{prod_c[PROD_W-1], prod_c[WIDTH-1:0]};
    push_c        = stage_vld && room_c;
    push_data_c   = stage_word;
    gen_ce_c      = !stage_vld || push_c;
  end

  // Scaling pipeline register between LFSR and buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || set_seed) begin
      stage_vld  <= 1'b0;
      stage_word <= '0;
    end else if (gen_ce_c) begin
      stage_vld  <= 1'b1;
      stage_word <= scaled_c;
    end
  end
`else
  // Raw words go straight into the buffer whenever there is room.
  always_comb begin
    push_c      = room_c;
    push_data_c = raw_word_c;
    gen_ce_c    = room_c;
  end
`endif

  // Next occupancy, read pointer and head word for the registered outputs.
  always_comb begin
    level_nxt_c  = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + LEVEL_W'(1);
    end else if (!push_c && pop_c) begin
      level_nxt_c = level - LEVEL_W'(1);
    end
    after_pop_c  = pop_c ? (level - LEVEL_W'(1)) : level;
    rd_ptr_nxt_c = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    if (push_c && (after_pop_c == '0)) begin
      head_nxt_c = push_data_c;
    end else begin
      head_nxt_c = mem[rd_ptr_nxt_c];
    end
  end

  // Buffer storage, written at the tail.
  always_ff @(posedge clk) begin
    if (rst_n && !set_seed && push_c) begin
      mem[wr_ptr] <= push_data_c;
    end
  end

  // Pointers, level, registered head/valid and saturating underrun counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      valid        <= 1'b0;
      random       <= '0;
      underrun_cnt <= '0;
    end else if (set_seed) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      random <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt_c;
      level  <= level_nxt_c;
      valid  <= (level_nxt_c != '0);
      random <= (level_nxt_c != '0) ? head_nxt_c : '0;
      if (underrun_c && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prng_fifo_source.sv
// Directed self-checking bench for prng_fifo_source (64-bit and 8-bit builds).
module tb_prng_fifo_source;

`ifdef PRNG_RANGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n64 = 1'b0, set_seed64 = 1'b0, ack64 = 1'b0, valid64;
  logic [62:0] seed64 = '0;
  logic [63:0] random64, range_max64 = '1;
  logic [4:0]  level64;
  logic [15:0] ur64;

  logic        rst_n8 = 1'b0, set_seed8 = 1'b0, ack8 = 1'b0, valid8;
  logic [62:0] seed8 = '0;
  logic [7:0]  random8, range_max8 = '1;
  logic [2:0]  level8;
  logic [1:0]  ur8;

  int checks = 0;
  int passed = 0;
  logic [62:0] m64, m8, tmp;
  logic [63:0] e64;
  logic [7:0]  e8;

  prng_fifo_source #(.WIDTH(64), .DEPTH(16), .UNDERRUN_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n64), .seed(seed64), .set_seed(set_seed64),
`ifdef PRNG_RANGE_EN
    .range_max(range_max64),
`endif
    .random(random64), .valid(valid64), .read_ack(ack64),
    .level(level64), .underrun_cnt(ur64)
  );

  prng_fifo_source #(.WIDTH(8), .DEPTH(4), .UNDERRUN_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n8), .seed(seed8), .set_seed(set_seed8),
`ifdef PRNG_RANGE_EN
    .range_max(range_max8),
`endif
    .random(random8), .valid(valid8), .read_ack(ack8),
    .level(level8), .underrun_cnt(ur8)
  );

  // Reference LFSR: one bit at a time, MSB of the word produced first.
  function automatic logic [63:0] model_word(inout logic [62:0] s, input int w);
    logic [63:0] r;
    logic nb;
    r = '0;
    for (int i = 0; i < w; i++) begin
      nb = s[62] ^ s[61];
      s = {s[61:0], nb};
      r[w-1-i] = nb;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (valid64 !== 1'b0) $display("FAIL reset_valid64: got %b want 0", valid64); else passed++;
    checks++; if (random64 !== 64'h0) $display("FAIL reset_random64: got %h want 0", random64); else passed++;
    checks++; if (level64 !== 5'd0) $display("FAIL reset_level64: got %0d want 0", level64); else passed++;
    checks++; if (ur64 !== 16'd0) $display("FAIL reset_ur64: got %0d want 0", ur64); else passed++;
    checks++; if (level8 !== 3'd0) $display("FAIL reset_level8: got %0d want 0", level8); else passed++;
    checks++; if (valid8 !== 1'b0) $display("FAIL reset_valid8: got %b want 0", valid8); else passed++;
  endtask

  task automatic test_stream64();
    m64 = 63'h1;
    rst_n64 = 1'b1;
    ack64 = 1'b1;
`ifdef PRNG_RANGE_EN
    tick();
    checks++; if (valid64 !== 1'b0) $display("FAIL stream_early_valid: got %b want 0", valid64); else passed++;
`endif
    tick();
    checks++; if (valid64 !== 1'b1) $display("FAIL stream_first_valid: got %b want 1", valid64); else passed++;
    checks++; if (random64 !== 64'h6) $display("FAIL stream_word1_const: got %h want 6", random64); else passed++;
    e64 = model_word(m64, 64);
    checks++; if (random64 !== e64) $display("FAIL stream_word1_model: got %h want %h", random64, e64); else passed++;
    for (int i = 2; i <= 21; i++) begin
      tick();
      e64 = model_word(m64, 64);
      checks++; if (random64 !== e64) $display("FAIL stream_word%0d: got %h want %h", i, random64, e64); else passed++;
    end
    checks++; if (level64 !== 5'd1) $display("FAIL stream_level: got %0d want 1", level64); else passed++;
    checks++; if (ur64 !== 16'(LAT)) $display("FAIL stream_underrun: got %0d want %0d", ur64, LAT); else passed++;
  endtask

  task automatic test_midreset();
    ack64 = 1'b0;
    tick();
    tick();
    checks++; if (level64 !== 5'd3) $display("FAIL midrst_level_pre: got %0d want 3", level64); else passed++;
    rst_n64 = 1'b0;
    tick();
    checks++; if (level64 !== 5'd0) $display("FAIL midrst_level: got %0d want 0", level64); else passed++;
    checks++; if (valid64 !== 1'b0) $display("FAIL midrst_valid: got %b want 0", valid64); else passed++;
    checks++; if (random64 !== 64'h0) $display("FAIL midrst_random: got %h want 0", random64); else passed++;
    checks++; if (ur64 !== 16'd0) $display("FAIL midrst_ur: got %0d want 0", ur64); else passed++;
    rst_n64 = 1'b1;
    repeat (LAT) tick();
    checks++; if (random64 !== 64'h6) $display("FAIL midrst_restart: got %h want 6", random64); else passed++;
  endtask

  task automatic test_fill8();
    m8 = 63'h1;
    rst_n8 = 1'b1;
    ack8 = 1'b0;
    repeat (10) tick();
    checks++; if (level8 !== 3'd4) $display("FAIL fill_level: got %0d want 4", level8); else passed++;
    checks++; if (valid8 !== 1'b1) $display("FAIL fill_valid: got %b want 1", valid8); else passed++;
    tmp = 63'h1;
    repeat (3 + LAT) e8 = 8'(model_word(tmp, 8));
    checks++; if (dut8.u_core.state !== tmp) $display("FAIL fill_frozen_state: got %h want %h", dut8.u_core.state, tmp); else passed++;
    for (int i = 0; i < 6; i++) begin
      e8 = 8'(model_word(m8, 8));
      checks++; if (random8 !== e8) $display("FAIL fill_pop%0d: got %h want %h", i, random8, e8); else passed++;
      ack8 = 1'b1;
      tick();
    end
    ack8 = 1'b0;
    tick();
    e8 = 8'(model_word(m8, 8));
    checks++; if (random8 !== e8) $display("FAIL fill_after_pops: got %h want %h", random8, e8); else passed++;
    checks++; if (ur8 !== 2'd0) $display("FAIL fill_ur: got %0d want 0", ur8); else passed++;
  endtask

  task automatic test_reseed8();
    checks++; if (level8 !== 3'd4) $display("FAIL reseed_level_pre: got %0d want 4", level8); else passed++;
    seed8 = '0;
    set_seed8 = 1'b1;
    ack8 = 1'b1;
    tick();
    set_seed8 = 1'b0;
    checks++; if (level8 !== 3'd0) $display("FAIL reseed_level: got %0d want 0", level8); else passed++;
    checks++; if (valid8 !== 1'b0) $display("FAIL reseed_valid: got %b want 0", valid8); else passed++;
    checks++; if (ur8 !== 2'd0) $display("FAIL reseed_ur_kept: got %0d want 0", ur8); else passed++;
    m8 = 63'h1;
    repeat (LAT) tick();
    checks++; if (valid8 !== 1'b1) $display("FAIL reseed_valid_back: got %b want 1", valid8); else passed++;
    e8 = 8'(model_word(m8, 8));
    checks++; if (random8 !== e8) $display("FAIL reseed_word0: got %h want %h", random8, e8); else passed++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      e8 = 8'(model_word(m8, 8));
      checks++; if (random8 !== e8) $display("FAIL reseed_word%0d: got %h want %h", i, random8, e8); else passed++;
      if (i == 7) begin
        checks++; if (random8 !== 8'h06) $display("FAIL reseed_word7_const: got %h want 06", random8); else passed++;
      end
    end
    checks++; if (ur8 !== 2'(LAT)) $display("FAIL reseed_ur_count: got %0d want %0d", ur8, LAT); else passed++;
    for (int k = 0; k < 3; k++) begin
      set_seed8 = 1'b1;
      tick();
      set_seed8 = 1'b0;
      repeat (LAT) tick();
    end
    checks++; if (ur8 !== 2'd3) $display("FAIL reseed_ur_saturate: got %0d want 3", ur8); else passed++;
    ack8 = 1'b0;
  endtask

`ifdef PRNG_RANGE_EN
  task automatic test_range8();
    logic [7:0] w;
    range_max8 = 8'd9;
    seed8 = 63'h1;
    set_seed8 = 1'b1;
    tick();
    set_seed8 = 1'b0;
    ack8 = 1'b1;
    m8 = 63'h1;
    tick();
    tick();
    checks++; if (valid8 !== 1'b1) $display("FAIL range_valid: got %b want 1", valid8); else passed++;
    for (int i = 0; i < 16; i++) begin
      w = 8'(model_word(m8, 8));
      e8 = 8'((16'(w) * 16'd10) >> 8);
      checks++; if (random8 !== e8) $display("FAIL range_word%0d: got %0d want %0d", i, random8, e8); else passed++;
      checks++; if (random8 > 8'd9) $display("FAIL range_bound%0d: got %0d want <=9", i, random8); else passed++;
      tick();
    end
    ack8 = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) tick();
    test_reset();
    test_stream64();
    test_midreset();
    test_fill8();
    test_reseed8();
`ifdef PRNG_RANGE_EN
    test_range8();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
